// File: rtl/prog_loader_pkg.sv
// Shared encodings and constants for the serial program loader and its UART receiver.
package prog_loader_pkg;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_e;

  typedef enum logic [1:0] {
    L_IDLE  = 2'd0,
    L_ARMED = 2'd1,
    L_WRITE = 2'd2,
    L_DONE  = 2'd3
  } ld_state_e;

  // 50 MHz system clock at 9600 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 5208;

  // Depth of the program RAM; one image fills it exactly.
  localparam int RAM_DEPTH = 16;

endpackage

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART receiver: rx synchroniser, bit timer and receive FSM.
// Emits a one-cycle rx_valid with the byte, or a one-cycle stop_err on a low stop bit.
module uart_rx8
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       rx,
  output logic [7:0] data_o,
  output logic       rx_valid_o,
  output logic       stop_err_o
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

  logic            sync1_q, sync2_q;
  rx_state_e       state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;

  // Synchroniser presets high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= R_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      R_IDLE: begin
        timer_d = '0;
        if (!sync2_q) state_d = R_START;
      end
      R_START: begin
        // Mid start bit: a high line here was only a glitch.
        if (timer_q == HALF_LAST) begin
          timer_d = '0;
          bit_d   = '0;
          state_d = sync2_q ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (timer_q == FULL_LAST) begin
          timer_d = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = R_STOP;
        end
      end
      R_STOP: begin
        if (timer_q == FULL_LAST) begin
          timer_d = '0;
          state_d = R_IDLE;
          if (sync2_q) begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  assign data_o     = data_q;
  assign rx_valid_o = valid_q;
  assign stop_err_o = err_q;

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: writes a UART-delivered image into the program RAM
// at consecutive addresses from 0 while holding the CPU.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int NBYTES       = RAM_DEPTH,
  parameter int AW           = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          rx,
  input  logic          prog_mode,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_data,
  output logic          ram_we,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          frame_err,
  output logic [AW:0]   byte_count
);

  localparam logic [AW:0] COUNT_FULL = (AW+1)'(NBYTES);

  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          stop_err;

  ld_state_e     state_q, state_d;
  logic          pm_q;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   count_inc;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;
  logic          pm_rise;

  uart_rx8 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .clr       (clr),
    .rx        (rx),
    .data_o    (rx_byte),
    .rx_valid_o(rx_valid),
    .stop_err_o(stop_err)
  );

  assign pm_rise   = prog_mode & ~pm_q;
  assign count_inc = count_q + 1'b1;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= L_IDLE;
      pm_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pm_q    <= prog_mode;
      addr_q  <= addr_d;
      data_q  <= data_d;
      count_q <= count_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    count_d = count_q;
    done_d  = done_q;
    ferr_d  = ferr_q | stop_err;
    case (state_q)
      L_IDLE: begin
        // A byte finishing in the same cycle as the session start is dropped.
        if (pm_rise) begin
          state_d = L_ARMED;
          addr_d  = '0;
          count_d = '0;
          done_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      L_ARMED: begin
        if (!prog_mode) begin
          state_d = L_IDLE;
        end else if (rx_valid) begin
          data_d  = rx_byte;
          addr_d  = count_q[AW-1:0];
          state_d = L_WRITE;
        end
      end
      L_WRITE: begin
        // The strobe cycle always completes; a dropped prog_mode is honoured afterwards.
        count_d = count_inc;
        if (count_inc == COUNT_FULL) begin
          done_d  = 1'b1;
          state_d = prog_mode ? L_DONE : L_IDLE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = prog_mode ? L_ARMED : L_IDLE;
        end
      end
      L_DONE: begin
        if (!prog_mode) state_d = L_IDLE;
      end
      default: state_d = L_IDLE;
    endcase
  end

  assign ram_addr   = addr_q;
  assign ram_data   = data_q;
  assign ram_we     = (state_q == L_WRITE);
  assign cpu_hold   = (state_q != L_IDLE);
  assign load_done  = done_q;
  assign frame_err  = ferr_q;
  assign byte_count = count_q;

endmodule
